// File: rtl/mux4_arb_pkg.sv
// Shared types and sizes for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_arbiter_rr_pick.sv
// rr_pick: rotate-priority encoder; the first set request at or after ptr wins.
module rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the candidate closest to ptr is written last.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin owner of a shared 4:1 mux with a one-cycle handover gap.
// Optional hold-time limit and to_err pulse are compiled in with ARB_TIMEOUT_EN.
module mux4_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic             s1,
  output logic             s0,
  output logic             busy,
  output logic             to_err
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic             pick_any_c;
  logic             release_c;
  logic             timeout_c;

  // The registered select lines double as the current owner index.
  assign owner_c   = {s1, s0};
  assign release_c = rel | ~req[owner_c] | timeout_c;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any_c),
    .idx (pick_idx_c)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned     CNT_W    = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt;

  assign timeout_c = (state == GRANT) && (cnt == CNT_LAST);

  // Hold-time counter: zero outside a grant, saturating count during it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state != GRANT) || release_c) begin
      cnt <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  logic unused_hold;

  assign unused_hold = ^HOLD_MAX;
  assign timeout_c   = 1'b0;
`endif

  // Arbitration FSM with registered grant, select, busy and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      s1     <= 1'b0;
      s0     <= 1'b0;
      busy   <= 1'b0;
      to_err <= 1'b0;
    end else begin
      to_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any_c) begin
            state    <= GRANT;
            gnt      <= N_REQ'(1) << pick_idx_c;
            {s1, s0} <= pick_idx_c;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          // Select lines keep the last owner through the gap so the mux never glitches.
          if (release_c) begin
            state  <= IDLE;
            gnt    <= '0;
            busy   <= 1'b0;
            ptr    <= owner_c + IDX_W'(1);
            to_err <= timeout_c & ~rel;
          end
        end
      endcase
    end
  end

endmodule
